// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the fetch and decode stages
package mips_pkg;
    localparam int          ADDR_W_DEFAULT   = 32;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h8002_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {insn, pc} holding register for decode back-pressure
module fetch_skid_buffer
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic              i_flush,
    input  logic [31:0]       i_insn,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [31:0]       o_insn,
    output logic [ADDR_W-1:0] o_pc
);
    logic              r_valid;
    logic [31:0]       r_insn;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_insn  <= NOP_INSN;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_insn  <= i_insn;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_insn  = r_insn;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch.sv
// fetch: sequential instruction fetch with one-entry skid buffer and PC redirect
module fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       insn,
    output logic [ADDR_W-1:0] pc,
    output logic              enable_decode,
    output logic              misalign_err
);
    logic [ADDR_W-1:0] r_pc_f;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;
    logic              r_squash;
    logic              w_hold;
    logic              w_arrive;
    logic              w_skid_valid;
    logic [31:0]       w_skid_insn;
    logic [ADDR_W-1:0] w_skid_pc;

    assign w_hold    = stall && enable_decode;
    assign w_arrive  = r_inflight && !r_squash;
    assign imem_req  = !reset && !redirect_valid && !w_hold;
    assign imem_addr = r_pc_f;

    fetch_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_hold && w_arrive),
        .i_unload (!w_hold),
        .i_flush  (redirect_valid),
        .i_insn   (imem_rdata),
        .i_pc     (r_inflight_pc),
        .o_valid  (w_skid_valid),
        .o_insn   (w_skid_insn),
        .o_pc     (w_skid_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc_f        <= PC_RESET;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_squash      <= 1'b0;
            insn          <= NOP_INSN;
            pc            <= '0;
            enable_decode <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) r_inflight_pc <= r_pc_f;
            r_squash <= redirect_valid;
            if (redirect_valid && !is_aligned(redirect_pc[1:0])) misalign_err <= 1'b1;
            // Redirect drops the current output and any arrival, even under stall
            if (redirect_valid) begin
                r_pc_f        <= {redirect_pc[ADDR_W-1:2], 2'b00};
                enable_decode <= 1'b0;
            end else begin
                if (imem_req) r_pc_f <= r_pc_f + ADDR_W'(WORD_BYTES);
                if (!w_hold) begin
                    enable_decode <= w_skid_valid || w_arrive;
                    if (w_skid_valid) begin
                        insn <= w_skid_insn;
                        pc   <= w_skid_pc;
                    end else if (w_arrive) begin
                        insn <= imem_rdata;
                        pc   <= r_inflight_pc;
                    end
                end
            end
        end
    end
endmodule
